// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and memory port, with a memory-wait watchdog and halt trap.
module multicycle_control_unit #(
    parameter int OPC_W        = 6,
    parameter int ALUOP_W      = 3,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_source,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [3:0]         state,
    output logic               illegal_op,
    output logic               bus_error
);
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_EXEC_I    = 4'd10;
    localparam logic [3:0] S_I_WB      = 4'd11;
    localparam logic [3:0] S_HALT      = 4'd12;

    localparam logic [OPC_W-1:0] OP_R    = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'b100011);
    localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'b101011);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'b000100);
    localparam logic [OPC_W-1:0] OP_J    = OPC_W'(6'b000010);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b001000);
    localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(6'b001100);
    localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(6'b001101);

    localparam int CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    logic [3:0]       next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_state;
    logic             expire;

    assign mem_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    // A ready in the expiry cycle still completes the access.
    assign expire = mem_state && !mem_ready && (MEM_WAIT_MAX > 0)
                    && (wait_cnt == CNT_W'(MEM_WAIT_MAX));

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:     next_state = expire ? S_HALT : (mem_ready ? S_DECODE : S_FETCH);
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW)                            next_state = S_MEM_ADDR;
                else if (opcode == OP_R)                                           next_state = S_EXEC_R;
                else if (opcode == OP_BEQ)                                         next_state = S_BRANCH;
                else if (opcode == OP_J)                                           next_state = S_JUMP;
                else if (opcode == OP_ADDI || opcode == OP_ANDI || opcode == OP_ORI) next_state = S_EXEC_I;
                else                                                               next_state = S_HALT;
            end
            S_MEM_ADDR:  next_state = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  next_state = expire ? S_HALT : (mem_ready ? S_MEM_WB : S_MEM_READ);
            S_MEM_WRITE: next_state = expire ? S_HALT : (mem_ready ? S_FETCH : S_MEM_WRITE);
            S_EXEC_R:    next_state = S_R_WB;
            S_BRANCH:    next_state = S_FETCH;
            S_JUMP:      next_state = S_FETCH;
            S_EXEC_I:    next_state = S_I_WB;
            S_HALT:      next_state = S_HALT;
            default:     next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            wait_cnt   <= '0;
            illegal_op <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            state <= next_state;
            if (mem_state && !mem_ready) begin
                if (wait_cnt != '1) wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (state == S_DECODE && next_state == S_HALT) illegal_op <= 1'b1;
            if (expire) bus_error <= 1'b1;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = '0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_W'(3'b100);
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALUOP_W'(3'b100);
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALUOP_W'(3'b100);
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_W'(3'b010);
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_W'(3'b111);
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_ANDI)     alu_op = ALUOP_W'(3'b101);
                else if (opcode == OP_ORI) alu_op = ALUOP_W'(3'b110);
                else                       alu_op = ALUOP_W'(3'b100);
            end
            S_I_WB: reg_write = 1'b1;
            default: ;
        endcase
        // Held in reset: no request or write may leak onto the datapath.
        if (!rst_n) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_source     = 2'b00;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = '0;
        end
    end
endmodule
